// File: rtl/m_vector_streamer.sv
// -----------------------------------------------------------------------------
// m_vector_streamer
//
// Purpose: on request, streams a burst of FILTER_LEN elements out of a vector
// memory into a small output FIFO. Element k of a burst is read from row
// ROW_OFFSET + layer + k*ROW_STRIDE of the current column. After every burst
// the position counters advance (layer -> minor -> major), so repeated bursts
// sweep every layer of every column. Read issue is throttled so that FIFO
// occupancy plus reads still in flight never exceeds FIFO_DEPTH, which means
// returning data always has a free slot.
//
// Ports:
//   clock                 rising-edge clock
//   clear                 synchronous active-high reset, highest priority
//   en                    global enable; 0 stalls new address issue
//   vector_element        read data, valid MEM_LATENCY cycles after a strobe
//   vector_memory_address registered read address {row, col}
//   memory_enable         registered read strobe
//   memory_write          tied to 0 (read-only client)
//   m_element_requested   burst start request, honoured in IDLE only
//   m_element_valid       FIFO head valid
//   m_element_ready       consumer accepts the head when valid & ready
//   m_element             FIFO head data (0 while empty)
//   busy                  burst in progress (state != IDLE)
//   burst_done            one-cycle pulse as the burst completes
//   sweep_done            one-cycle pulse when all position counters wrap
// -----------------------------------------------------------------------------
module m_vector_streamer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int FILTER_LEN  = 8,
    parameter int LAYERS      = 4,
    parameter int ROW_OFFSET  = 4,
    parameter int ROW_STRIDE  = 4,
    parameter int MEM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] vector_element,
    output logic [ADDR_W-1:0] vector_memory_address,
    output logic              memory_enable,
    output logic              memory_write,
    input  logic              m_element_requested,
    output logic              m_element_valid,
    input  logic              m_element_ready,
    output logic [DATA_W-1:0] m_element,
    output logic              busy,
    output logic              burst_done,
    output logic              sweep_done
);

    localparam int ROW_W   = ADDR_W - 4;
    localparam int LAYER_W = $clog2(LAYERS);
    localparam int IC_W    = $clog2(FILTER_LEN + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W    = CNT_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t             state, state_nxt;
    logic [IC_W-1:0]    issue_cnt;
    logic [LAYER_W-1:0] layer;
    logic [1:0]         minor;
    logic [1:0]         major;

    // Bit 0 is the read strobe itself; bit MEM_LATENCY marks the cycle in
    // which that read's data is on vector_element.
    logic [MEM_LATENCY:0] rd_pipe;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              issue;
    logic              push, pop;
    logic [CR_W-1:0]   inflight;
    logic [CR_W-1:0]   credit;
    logic [ROW_W-1:0]  row_k;
    logic [3:0]        col;

    assign col  = {major[1], minor[1], major[0], minor[0]};
    assign push = rd_pipe[MEM_LATENCY];
    assign pop  = m_element_valid && m_element_ready;

    assign memory_enable   = rd_pipe[0];
    assign memory_write    = 1'b0;
    assign busy            = (state != S_IDLE);
    assign m_element_valid = (fifo_count != '0);
    assign m_element       = m_element_valid ? fifo_mem[rd_ptr] : '0;

    // Row of the next element to issue; truncation to the row field is the
    // intended wrap behaviour.
    assign row_k = ROW_W'(ROW_OFFSET) + ROW_W'(layer) + ROW_W'(issue_cnt * ROW_STRIDE);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_nxt  = state;
        issue      = 1'b0;
        burst_done = 1'b0;
        sweep_done = 1'b0;

        inflight = '0;
        for (int i = 0; i <= MEM_LATENCY; i++) begin
            inflight = inflight + CR_W'(rd_pipe[i]);
        end
        // Every issued read owns a FIFO slot from issue until it is popped.
        credit = CR_W'(fifo_count) + inflight;

        case (state)
            S_IDLE: begin
                if (m_element_requested && en) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (en && (credit < CR_W'(FIFO_DEPTH))) begin
                    issue = 1'b1;
                    if (issue_cnt == IC_W'(FILTER_LEN - 1)) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight == '0) begin
                    burst_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        sweep_done = burst_done && (layer == LAYER_W'(LAYERS - 1)) &&
                     (minor == 2'd3) && (major == 2'd3);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (clear) begin
            state                 <= S_IDLE;
            issue_cnt             <= '0;
            layer                 <= '0;
            minor                 <= '0;
            major                 <= '0;
            rd_pipe               <= '0;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            fifo_count            <= '0;
            vector_memory_address <= '0;
        end else begin
            state   <= state_nxt;
            rd_pipe <= {rd_pipe[MEM_LATENCY-1:0], issue};

            if (state == S_IDLE) begin
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt             <= issue_cnt + IC_W'(1);
                vector_memory_address <= {row_k, col};
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

            // Counters wrap naturally at their widths, so a full sweep
            // returns all of them to zero.
            if (burst_done) begin
                layer <= layer + LAYER_W'(1);
                if (layer == LAYER_W'(LAYERS - 1)) begin
                    minor <= minor + 2'd1;
                    if (minor == 2'd3) begin
                        major <= major + 2'd1;
                    end
                end
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count define which
    // entries are meaningful, and m_element is forced to 0 while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= vector_element;
        end
    end

endmodule

// File: tb/tb_m_vector_streamer.sv
module tb_m_vector_streamer;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 10;
    localparam int FILTER_LEN  = 8;
    localparam int MEM_LATENCY = 1;

    logic              clock = 1'b0;
    logic              clear;
    logic              en;
    logic [DATA_W-1:0] vector_element;
    logic [ADDR_W-1:0] vector_memory_address;
    logic              memory_enable;
    logic              memory_write;
    logic              m_element_requested;
    logic              m_element_valid;
    logic              m_element_ready;
    logic [DATA_W-1:0] m_element;
    logic              busy;
    logic              burst_done;
    logic              sweep_done;

    always #5 clock = ~clock;

    m_vector_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FILTER_LEN(FILTER_LEN), .LAYERS(4),
        .ROW_OFFSET(4), .ROW_STRIDE(4), .MEM_LATENCY(MEM_LATENCY), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .clear(clear),
        .en(en),
        .vector_element(vector_element),
        .vector_memory_address(vector_memory_address),
        .memory_enable(memory_enable),
        .memory_write(memory_write),
        .m_element_requested(m_element_requested),
        .m_element_valid(m_element_valid),
        .m_element_ready(m_element_ready),
        .m_element(m_element),
        .busy(busy),
        .burst_done(burst_done),
        .sweep_done(sweep_done)
    );

    // Vector memory model: random contents, data valid MEM_LATENCY cycles
    // after the strobe, random garbage on the bus otherwise.
    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] d_pipe [MEM_LATENCY];

    always @(posedge clock) begin
        d_pipe[0] <= memory_enable ? mem[vector_memory_address] : DATA_W'($urandom);
        for (int i = 1; i < MEM_LATENCY; i++) d_pipe[i] <= d_pipe[i-1];
    end
    assign vector_element = d_pipe[MEM_LATENCY-1];

    // Monitor: sampled on the falling edge, away from the active edge.
    int cyc = 0;
    int iss_q[$];
    int iss_cyc[$];
    int out_q[$];
    int bd_cnt = 0;
    int sw_cnt = 0;
    int sw_bad = 0;
    int sw_at  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (memory_enable) begin
            iss_q.push_back(int'(vector_memory_address));
            iss_cyc.push_back(cyc);
        end
        if (m_element_valid && m_element_ready) out_q.push_back(int'(m_element));
        if (burst_done) bd_cnt++;
        if (sweep_done) begin
            sw_cnt++;
            sw_at = bd_cnt;
            if (!burst_done) sw_bad++;
        end
    end

    int total = 0;
    int bad   = 0;
    int b_idx = 0;
    int bd_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: address of element k in burst b counted from the last clear.
    function automatic int model_addr(input int b, input int k);
        int layer, minor, major, col, row;
        layer = b % 4;
        minor = (b / 4) % 4;
        major = (b / 16) % 4;
        col   = ((major >> 1) & 1) * 8 + ((minor >> 1) & 1) * 4 +
                (major & 1) * 2 + (minor & 1);
        row   = (4 + layer + 4 * k) % 64;
        return row * 16 + col;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_burst();
        iss_q.delete();
        iss_cyc.delete();
        out_q.delete();
        bd_start = bd_cnt;
        chk("idle_before_req", busy, 0);
        m_element_requested = 1'b1;
        en = 1'b1;
        step();
        m_element_requested = 1'b0;
        chk("busy_after_req", busy, 1);
    endtask

    task automatic finish_burst(input bit rnd);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            if (rnd) begin
                m_element_ready = ($urandom_range(0, 3) != 0);
                en              = ($urandom_range(0, 3) != 0);
            end
            step();
            done = (bd_cnt == bd_start + 1) && (out_q.size() >= FILTER_LEN);
        end
        en = 1'b1;
        m_element_ready = 1'b1;
        chk($sformatf("burst_timeout b%0d", b_idx), done, 1);
        chk($sformatf("burst_done_count b%0d", b_idx), bd_cnt - bd_start, 1);
        chk($sformatf("issue_count b%0d", b_idx), iss_q.size(), FILTER_LEN);
        chk($sformatf("out_count b%0d", b_idx), out_q.size(), FILTER_LEN);
        for (int k = 0; k < FILTER_LEN; k++) begin
            if (k < iss_q.size())
                chk($sformatf("addr b%0d k%0d", b_idx, k), iss_q[k], model_addr(b_idx, k));
            if (k < out_q.size())
                chk($sformatf("data b%0d k%0d", b_idx, k), out_q[k],
                    int'(mem[model_addr(b_idx, k)]));
        end
        step();
        chk($sformatf("fifo_empty_after b%0d", b_idx), m_element_valid, 0);
        chk($sformatf("idle_after b%0d", b_idx), busy, 0);
        b_idx++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
        clear = 1'b1;
        en = 1'b0;
        m_element_requested = 1'b0;
        m_element_ready = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_element_valid, 0);
        chk("rst_mem_en", memory_enable, 0);
        chk("rst_addr", vector_memory_address, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_m_element", m_element, 0);
        chk("rst_mem_write", memory_write, 0);
        clear = 1'b0;

        // Burst 0: request right after clear, consumer always ready
        m_element_ready = 1'b1;
        start_burst();
        finish_burst(1'b0);
        chk("b0_first_addr", iss_q[0], 64);
        chk("b0_last_addr", iss_q[FILTER_LEN-1], 512);
        chk("b0_consecutive", iss_cyc[FILTER_LEN-1] - iss_cyc[0], FILTER_LEN - 1);

        // Burst 1: consumer stalled, issue must stop at FIFO capacity
        m_element_ready = 1'b0;
        start_burst();
        repeat (20) step();
        chk("stall_issue_count", iss_q.size(), 4);
        chk("stall_valid", m_element_valid, 1);
        chk("stall_head", m_element, mem[model_addr(b_idx, 0)]);
        step();
        chk("stall_head_held", m_element, mem[model_addr(b_idx, 0)]);
        chk("stall_b1_first_addr", iss_q[0], 80);
        m_element_ready = 1'b1;
        finish_burst(1'b0);

        // Burst 2: en dropped for 3 cycles after the second issue
        start_burst();
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("en_low_mem_en c%0d", i), memory_enable, 0);
            chk($sformatf("en_low_addr_held c%0d", i), vector_memory_address,
                model_addr(b_idx, 1));
        end
        en = 1'b1;
        finish_burst(1'b0);

        // Bursts 3..63 with random ready and en
        while (b_idx < 64) begin
            start_burst();
            finish_burst(1'b1);
            if (b_idx == 5)  chk("b4_first_addr", iss_q[0], 65);
            if (b_idx == 17) chk("b16_first_addr", iss_q[0], 66);
            if (b_idx == 63) chk("no_early_sweep", sw_cnt, 0);
        end
        chk("sweep_count", sw_cnt, 1);
        chk("sweep_at_burst", sw_at, 64);
        chk("sweep_with_burst_done", sw_bad, 0);

        // 65th burst restarts the sweep
        start_burst();
        finish_burst(1'b1);
        chk("b64_first_addr", iss_q[0], 64);

        // Clear on the third issue cycle aborts the burst
        start_burst();
        step();
        step();
        clear = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_valid", m_element_valid, 0);
        chk("abort_mem_en", memory_enable, 0);
        chk("abort_addr", vector_memory_address, 0);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("abort_no_stale c%0d", i), m_element_valid, 0);
        end
        b_idx = 0;
        start_burst();
        finish_burst(1'b0);
        chk("after_abort_first_addr", iss_q[0], 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_vector_streamer.md
M_VECTOR_STREAMER -- requirements
Module: m_vector_streamer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 DATA_W 16 element width
 ADDR_W 10 memory address width; row field = ADDR_W-4 bits, col field = 4 bits
 FILTER_LEN 8 elements per burst, >=1
 LAYERS 4 layers per column, power of 2, >=2
 ROW_OFFSET 4 row of element 0 at layer 0
 ROW_STRIDE 4 row increment between burst elements
 MEM_LATENCY 1 cycles from address (memory_enable=1) to vector_element valid, 1..3
 FIFO_DEPTH 4 output buffer entries, power of 2, >=2
REQ-002 Ports (name, direction, width, meaning), one per line:
 clock in 1 sole clock, rising edge
 clear in 1 synchronous active-high reset
 en in 1 global enable; 0 stalls new address issue
 vector_element in DATA_W read data from vector memory
 vector_memory_address out ADDR_W read address, registered
 memory_enable out 1 read strobe, registered
 memory_write out 1 constant 0
 m_element_requested in 1 burst start request, sampled in IDLE only
 m_element_valid out 1 FIFO head valid
 m_element_ready in 1 consumer accepts head when valid&ready
 m_element out DATA_W FIFO head data
 busy out 1 state != IDLE
 burst_done out 1 one-cycle pulse at burst completion
 sweep_done out 1 one-cycle pulse when full position sweep wraps

Function
REQ-003 Position counters: layer (log2 LAYERS bits), minor (2 bits), major (2 bits); col = {major[1],minor[1],major[0],minor[0]}.
REQ-004 Element k (0..FILTER_LEN-1) address = {row_k, col}, row_k = ROW_OFFSET + layer + k*ROW_STRIDE, truncated to ADDR_W-4 bits.
REQ-005 FSM states: IDLE, FETCH, DRAIN.
REQ-006 IDLE -> FETCH when m_element_requested=1 and en=1; request in FETCH/DRAIN ignored, not queued.
REQ-007 FETCH: one read per cycle, memory_enable=1 with address, only when en=1 and (FIFO occupancy + in-flight reads) < FIFO_DEPTH; else memory_enable=0, address held.
REQ-008 FETCH -> DRAIN in the cycle the FILTER_LEN-th read issues.
REQ-009 Read data captured into FIFO exactly MEM_LATENCY cycles after issue via valid shift register, independent of en; no data ever dropped or duplicated.
REQ-010 DRAIN -> IDLE once in-flight count = 0; burst_done pulses that cycle; FIFO need not be empty.
REQ-011 At burst_done: layer+1; layer wrap -> minor+1; minor wrap -> major+1; major wrap -> all counters 0 and sweep_done pulses same cycle as burst_done.
REQ-012 FIFO: simultaneous push and pop at full or empty legal, occupancy unchanged; m_element valid same cycle as m_element_valid; head held stable while valid and not ready.
REQ-013 Elements emerge in issue order k=0..FILTER_LEN-1; bursts never interleave.
REQ-014 busy=1 from cycle after accepted request through DRAIN->IDLE transition cycle.

Reset
REQ-015 clear=1 at a rising edge: state IDLE, counters 0, FIFO empty, in-flight 0, valid pipe 0; all outputs 0, vector_memory_address 0.
REQ-016 clear has priority over every other input, incl. mid-burst; returning data of aborted reads discarded.
REQ-017 First request after clear accepted the cycle following clear deassertion.

Verification (defaults)
REQ-018 clear, then request pulse, m_element_ready=1 -> addresses 64,128,...,512 (rows 4..32, col 0) on 8 consecutive cycles; 8 elements out in order; one burst_done.
REQ-019 Second request -> rows 5..33, addresses 80,144,...,528; 4th burst ends -> minor=1, 5th burst addresses 65,129,...
REQ-020 m_element_ready=0 throughout burst -> exactly 4 reads issued, m_element_valid=1 with first element held; asserting ready resumes issue, all 8 delivered, none lost.
REQ-021 64 back-to-back bursts -> 16th burst_done leaves col=0010; sweep_done only with 64th burst_done; 65th burst uses address 64.
REQ-022 clear asserted on 3rd issue cycle of a burst -> next cycle idle, FIFO empty, no m_element_valid from stale data; new request restarts at address 64.
REQ-023 en=0 mid-FETCH for 3 cycles -> memory_enable=0, address held; outstanding data still captured; burst completes with 8 elements after en=1.
